// File: rtl/hazard_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hazard_pkg                                                      |
// | Purpose  : Shared types and constants for the load-use hazard controller.  |
// |            Holds the FSM state encoding, the hardwired-zero register       |
// |            index and the width of the remaining-stall-cycle counter.      |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package hazard_pkg;

  // Controller FSM state encoding (one bit, explicit width).
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  // Register index that is hardwired to zero and can never carry a hazard.
  localparam int REG_ZERO = 0;

  // Width of the remaining-stall-cycle counter; bounds LOAD_LAT to 1..15.
  localparam int REM_W = 4;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_cmp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hazard_cmp                                                      |
// | Purpose  : Combinational NUM_SRC-way comparator. Flags a load-use hazard   |
// |            when any used source operand of the instruction in ID matches   |
// |            the non-zero destination of a valid load in EX.                 |
// | Ports    : ifid_valid, ifid_src, ifid_src_used - instruction in ID         |
// |            idex_valid, idex_memread, idex_dest - instruction in EX         |
// |            hit                                 - load-use hazard detected  |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module hazard_cmp
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
) (
  input  logic                      ifid_valid,
  input  logic [NUM_SRC*REG_AW-1:0] ifid_src,
  input  logic [NUM_SRC-1:0]        ifid_src_used,
  input  logic                      idex_valid,
  input  logic                      idex_memread,
  input  logic [REG_AW-1:0]         idex_dest,
  output logic                      hit
);

  logic [NUM_SRC-1:0] w_match;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign w_match[gi] = ifid_src_used[gi] &
                           (ifid_src[gi*REG_AW +: REG_AW] == idex_dest);
    end
  endgenerate

  assign hit = ifid_valid & idex_valid & idex_memread &
               (idex_dest != REG_AW'(REG_ZERO)) & (|w_match);

endmodule : hazard_cmp
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hazard_ctrl                                                     |
// | Purpose  : Load-use hazard and stall controller between IF/ID and ID/EX.  |
// |            Stalls LOAD_LAT cycles per load-use hazard, freezes on data    |
// |            memory wait, flushes on taken branches and keeps a saturating  |
// |            count of PC-stall cycles.                                      |
// | Ports    : clk, rst_n          - clock, async active-low reset            |
// |            ifid_* / idex_*     - pipeline register contents               |
// |            mem_wait            - data memory not ready                    |
// |            branch_taken        - branch resolved taken in EX              |
// |            clr_stats           - synchronous clear of stall_cnt           |
// |            stall_pc, stall_ifid, bubble_idex, flush_ifid - Mealy controls |
// |            stall_cnt           - saturating stall-cycle statistic         |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,   // legal range 1..15
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ifid_valid,
  input  logic [NUM_SRC*REG_AW-1:0] ifid_src,
  input  logic [NUM_SRC-1:0]        ifid_src_used,
  input  logic                      idex_valid,
  input  logic                      idex_memread,
  input  logic [REG_AW-1:0]         idex_dest,
  input  logic                      mem_wait,
  input  logic                      branch_taken,
  input  logic                      clr_stats,
  output logic                      stall_pc,
  output logic                      stall_ifid,
  output logic                      bubble_idex,
  output logic                      flush_ifid,
  output logic [CNT_W-1:0]          stall_cnt
);

  // Cycles still to stall after the cycle in which the hazard was seen.
  localparam logic [REM_W-1:0] c_rem_init = REM_W'(LOAD_LAT - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [REM_W-1:0] r_rem;
  logic [REM_W-1:0] w_rem_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;
  logic             w_stall;
  logic             w_bubble;
  logic             w_flush;

  hazard_cmp #(
    .REG_AW  (REG_AW),
    .NUM_SRC (NUM_SRC)
  ) u_cmp (
    .ifid_valid    (ifid_valid),
    .ifid_src      (ifid_src),
    .ifid_src_used (ifid_src_used),
    .idex_valid    (idex_valid),
    .idex_memread  (idex_memread),
    .idex_dest     (idex_dest),
    .hit           (w_hit)
  );

  // Priority: mem_wait > branch_taken > ongoing STALL > new hit.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_stall     = 1'b0;
    w_bubble    = 1'b0;
    w_flush     = 1'b0;
    if (mem_wait) begin
      // Freeze everything, including the stall sequence itself.
      w_stall = 1'b1;
    end else if (branch_taken) begin
      // Wrong-path instruction in ID is discarded, so any hazard is moot.
      w_flush     = 1'b1;
      w_bubble    = 1'b1;
      w_state_nxt = IDLE;
      w_rem_nxt   = '0;
    end else if (r_state == STALL) begin
      w_stall   = 1'b1;
      w_bubble  = 1'b1;
      w_rem_nxt = r_rem - REM_W'(1);
      if (r_rem == REM_W'(1)) begin
        w_state_nxt = IDLE;
      end
    end else if (w_hit) begin
      w_stall  = 1'b1;
      w_bubble = 1'b1;
      if (LOAD_LAT > 1) begin
        w_state_nxt = STALL;
        w_rem_nxt   = c_rem_init;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_stats) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Outputs are Mealy, so they are gated by rst_n to stay quiet in reset
  // even while the inputs present a hazard.
  assign stall_pc    = rst_n & w_stall;
  assign stall_ifid  = rst_n & w_stall;
  assign bubble_idex = rst_n & w_bubble;
  assign flush_ifid  = rst_n & w_flush;
  assign stall_cnt   = r_cnt;

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hazard_ctrl                                                  |
// | Purpose  : Self-checking bench for hazard_ctrl. Three instances:           |
// |            d0 LOAD_LAT=1/CNT_W=16, d1 LOAD_LAT=3/CNT_W=16,                 |
// |            d2 LOAD_LAT=1/CNT_W=4. Only the addressed instance sees         |
// |            ifid_valid, so the others stay idle.                           |
// |            Expected control bits are {stall_pc,stall_ifid,bubble,flush}.  |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_hazard_ctrl;

  typedef struct {
    int         dut;
    logic [3:0] ctl;
    int         cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  iv = '0;
  logic [9:0]  src = '0;
  logic [1:0]  used = '0;
  logic        ev = 1'b0;
  logic        mr = 1'b0;
  logic [4:0]  dst = '0;
  logic        mw = 1'b0;
  logic        br = 1'b0;
  logic        clr = 1'b0;

  logic [2:0]  spc, sif, bub, fl;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) d0 (
    .clk(clk), .rst_n(rst_n), .ifid_valid(iv[0]), .ifid_src(src),
    .ifid_src_used(used), .idex_valid(ev), .idex_memread(mr), .idex_dest(dst),
    .mem_wait(mw), .branch_taken(br), .clr_stats(clr),
    .stall_pc(spc[0]), .stall_ifid(sif[0]), .bubble_idex(bub[0]),
    .flush_ifid(fl[0]), .stall_cnt(cnt0));

  hazard_ctrl #(.LOAD_LAT(3), .CNT_W(16)) d1 (
    .clk(clk), .rst_n(rst_n), .ifid_valid(iv[1]), .ifid_src(src),
    .ifid_src_used(used), .idex_valid(ev), .idex_memread(mr), .idex_dest(dst),
    .mem_wait(mw), .branch_taken(br), .clr_stats(clr),
    .stall_pc(spc[1]), .stall_ifid(sif[1]), .bubble_idex(bub[1]),
    .flush_ifid(fl[1]), .stall_cnt(cnt1));

  hazard_ctrl #(.LOAD_LAT(1), .CNT_W(4)) d2 (
    .clk(clk), .rst_n(rst_n), .ifid_valid(iv[2]), .ifid_src(src),
    .ifid_src_used(used), .idex_valid(ev), .idex_memread(mr), .idex_dest(dst),
    .mem_wait(mw), .branch_taken(br), .clr_stats(clr),
    .stall_pc(spc[2]), .stall_ifid(sif[2]), .bubble_idex(bub[2]),
    .flush_ifid(fl[2]), .stall_cnt(cnt2));

  function automatic logic [3:0] ctl_of(input int d);
    return {spc[d], sif[d], bub[d], fl[d]};
  endfunction

  function automatic int cnt_of(input int d);
    case (d)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  task automatic drive(input logic [2:0] s_iv, input logic [9:0] s_src,
                       input logic [1:0] s_used, input logic s_ev,
                       input logic s_mr, input logic [4:0] s_dst,
                       input logic s_mw, input logic s_br, input logic s_clr);
    iv = s_iv; src = s_src; used = s_used; ev = s_ev; mr = s_mr;
    dst = s_dst; mw = s_mw; br = s_br; clr = s_clr;
  endtask

  // Kinds: 0 idle, 1 idle+clr, 2 hit, 3 mem_wait, 4 branch, 5 hit+branch, 6 hit+clr
  task automatic drive_kind(input int d, input int k);
    logic [2:0] sel;
    sel = 3'b001 << d;
    case (k)
      1:       drive(3'b000, 10'd0, 2'b00, 0, 0, 5'd0, 0, 0, 1);
      2:       drive(sel, {5'd3, 5'd7}, 2'b11, 1, 1, 5'd7, 0, 0, 0);
      3:       drive(3'b000, 10'd0, 2'b00, 0, 0, 5'd0, 1, 0, 0);
      4:       drive(3'b000, 10'd0, 2'b00, 0, 0, 5'd0, 0, 1, 0);
      5:       drive(sel, {5'd3, 5'd7}, 2'b11, 1, 1, 5'd7, 0, 1, 0);
      6:       drive(sel, {5'd3, 5'd7}, 2'b11, 1, 1, 5'd7, 0, 0, 1);
      default: drive(3'b000, 10'd0, 2'b00, 0, 0, 5'd0, 0, 0, 0);
    endcase
  endtask

  task automatic test_reset();
    exp_t e;
    @(posedge clk); #1;
    drive(3'b111, {5'd8, 5'd4}, 2'b11, 1, 1, 5'd4, 0, 0, 0);
    for (int d = 0; d < 3; d++) q.push_back('{d, 4'b0000, 0});
    #4;
    for (int d = 0; d < 3; d++) begin
      e = q.pop_front();
      total++;
      if (ctl_of(e.dut) !== e.ctl) begin
        bad++;
        $display("FAIL reset_ctl d%0d got=%b exp=%b", e.dut, ctl_of(e.dut), e.ctl);
      end
      total++;
      if (cnt_of(e.dut) !== e.cnt) begin
        bad++;
        $display("FAIL reset_cnt d%0d got=%0d exp=%0d", e.dut, cnt_of(e.dut), e.cnt);
      end
    end
    @(posedge clk); #1;
    drive_kind(0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lat1();
    exp_t e;
    int kind [3] = '{1, 2, 0};
    logic [3:0] cx [3] = '{4'b0000, 4'b1110, 4'b0000};
    int nx [3] = '{0, 1, 1};
    for (int c = 0; c < 3; c++) begin
      if (c == 1) drive(3'b001, {5'd8, 5'd4}, 2'b11, 1, 1, 5'd4, 0, 0, 0);
      else drive_kind(0, kind[c]);
      q.push_back('{0, cx[c], nx[c]});
      #4;
      e = q.pop_front();
      total++;
      if (ctl_of(e.dut) !== e.ctl) begin
        bad++;
        $display("FAIL lat1_ctl cyc%0d got=%b exp=%b", c, ctl_of(e.dut), e.ctl);
      end
      @(posedge clk); #1;
      total++;
      if (cnt_of(e.dut) !== e.cnt) begin
        bad++;
        $display("FAIL lat1_cnt cyc%0d got=%0d exp=%0d", c, cnt_of(e.dut), e.cnt);
      end
    end
  endtask

  task automatic test_no_hazard();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: drive_kind(0, 1);
        1: drive(3'b001, {5'd8, 5'd0}, 2'b11, 1, 1, 5'd0, 0, 0, 0);  // r0 match
        2: drive(3'b001, {5'd8, 5'd4}, 2'b10, 1, 1, 5'd4, 0, 0, 0);  // unused match
        default: drive(3'b001, {5'd8, 5'd4}, 2'b11, 1, 0, 5'd4, 0, 0, 0); // not a load
      endcase
      q.push_back('{0, 4'b0000, 0});
      #4;
      e = q.pop_front();
      total++;
      if (ctl_of(e.dut) !== e.ctl) begin
        bad++;
        $display("FAIL nohaz_ctl cyc%0d got=%b exp=%b", c, ctl_of(e.dut), e.ctl);
      end
      @(posedge clk); #1;
      total++;
      if (cnt_of(e.dut) !== e.cnt) begin
        bad++;
        $display("FAIL nohaz_cnt cyc%0d got=%0d exp=%0d", c, cnt_of(e.dut), e.cnt);
      end
    end
  endtask

  task automatic test_lat3();
    exp_t e;
    int kind [5] = '{1, 2, 0, 0, 0};
    logic [3:0] cx [5] = '{4'b0000, 4'b1110, 4'b1110, 4'b1110, 4'b0000};
    int nx [5] = '{0, 1, 2, 3, 3};
    for (int c = 0; c < 5; c++) begin
      drive_kind(1, kind[c]);
      q.push_back('{1, cx[c], nx[c]});
      #4;
      e = q.pop_front();
      total++;
      if (ctl_of(e.dut) !== e.ctl) begin
        bad++;
        $display("FAIL lat3_ctl cyc%0d got=%b exp=%b", c, ctl_of(e.dut), e.ctl);
      end
      @(posedge clk); #1;
      total++;
      if (cnt_of(e.dut) !== e.cnt) begin
        bad++;
        $display("FAIL lat3_cnt cyc%0d got=%0d exp=%0d", c, cnt_of(e.dut), e.cnt);
      end
    end
  endtask

  task automatic test_mem_wait();
    exp_t e;
    int kind [7] = '{1, 2, 3, 3, 0, 0, 0};
    logic [3:0] cx [7] = '{4'b0000, 4'b1110, 4'b1100, 4'b1100, 4'b1110, 4'b1110, 4'b0000};
    int nx [7] = '{0, 1, 2, 3, 4, 5, 5};
    for (int c = 0; c < 7; c++) begin
      drive_kind(1, kind[c]);
      q.push_back('{1, cx[c], nx[c]});
      #4;
      e = q.pop_front();
      total++;
      if (ctl_of(e.dut) !== e.ctl) begin
        bad++;
        $display("FAIL memwait_ctl cyc%0d got=%b exp=%b", c, ctl_of(e.dut), e.ctl);
      end
      @(posedge clk); #1;
      total++;
      if (cnt_of(e.dut) !== e.cnt) begin
        bad++;
        $display("FAIL memwait_cnt cyc%0d got=%0d exp=%0d", c, cnt_of(e.dut), e.cnt);
      end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    // hit, branch in 2nd stall cycle, idle; then hit+branch cancels, idle
    int kind [6] = '{1, 2, 4, 0, 5, 0};
    logic [3:0] cx [6] = '{4'b0000, 4'b1110, 4'b0011, 4'b0000, 4'b0011, 4'b0000};
    int nx [6] = '{0, 1, 1, 1, 1, 1};
    for (int c = 0; c < 6; c++) begin
      drive_kind(1, kind[c]);
      q.push_back('{1, cx[c], nx[c]});
      #4;
      e = q.pop_front();
      total++;
      if (ctl_of(e.dut) !== e.ctl) begin
        bad++;
        $display("FAIL branch_ctl cyc%0d got=%b exp=%b", c, ctl_of(e.dut), e.ctl);
      end
      @(posedge clk); #1;
      total++;
      if (cnt_of(e.dut) !== e.cnt) begin
        bad++;
        $display("FAIL branch_cnt cyc%0d got=%0d exp=%0d", c, cnt_of(e.dut), e.cnt);
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    int k;
    for (int c = 0; c < 23; c++) begin
      if (c == 0) begin
        k = 1; q.push_back('{2, 4'b0000, 0});
      end else if (c <= 20) begin
        k = 2; q.push_back('{2, 4'b1110, (c > 15) ? 15 : c});
      end else if (c == 21) begin
        k = 6; q.push_back('{2, 4'b1110, 0});  // clear wins over the stall
      end else begin
        k = 0; q.push_back('{2, 4'b0000, 0});
      end
      drive_kind(2, k);
      #4;
      e = q.pop_front();
      total++;
      if (ctl_of(e.dut) !== e.ctl) begin
        bad++;
        $display("FAIL sat_ctl cyc%0d got=%b exp=%b", c, ctl_of(e.dut), e.ctl);
      end
      @(posedge clk); #1;
      total++;
      if (cnt_of(e.dut) !== e.cnt) begin
        bad++;
        $display("FAIL sat_cnt cyc%0d got=%0d exp=%0d", c, cnt_of(e.dut), e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e;
    drive_kind(1, 2);
    @(posedge clk); #1;          // d1 now in STALL with two cycles left
    drive_kind(1, 0);
    #1;
    total++;
    if (ctl_of(1) !== 4'b1110) begin
      bad++;
      $display("FAIL rstmid_pre got=%b exp=%b", ctl_of(1), 4'b1110);
    end
    #1;
    rst_n = 1'b0;
    q.push_back('{1, 4'b0000, 0});
    #1;
    e = q.pop_front();
    total++;
    if (ctl_of(e.dut) !== e.ctl) begin
      bad++;
      $display("FAIL rstmid_ctl got=%b exp=%b", ctl_of(e.dut), e.ctl);
    end
    total++;
    if (cnt_of(e.dut) !== e.cnt) begin
      bad++;
      $display("FAIL rstmid_cnt got=%0d exp=%0d", cnt_of(e.dut), e.cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.push_back('{1, 4'b0000, 0});  // stall aborted: idle inputs give no stall
    #4;
    e = q.pop_front();
    total++;
    if (ctl_of(e.dut) !== e.ctl) begin
      bad++;
      $display("FAIL rstmid_after got=%b exp=%b", ctl_of(e.dut), e.ctl);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_lat1();
    test_no_hazard();
    test_lat3();
    test_mem_wait();
    test_branch();
    test_saturate();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hazard_ctrl
`default_nettype wire
